// File: rtl/ballot_input_controller.sv
// Ballot input controller: synchronizes and debounces three candidate buttons and
// emits at most one single-cycle vote pulse per ballot armed by the polling official.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// LOCKED   | no ballot open; waiting for arm
// ARMED    | ballot open; waiting for a press, timeout timer running
// DEBOUNCE | press pattern latched; waiting for it to stay stable
// CAST     | single cycle; vote pulse is high, count is updated on exit
// RELEASE  | waiting for all buttons to stay released
module ballot_input_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       arm,
  input  logic       btn_1,
  input  logic       btn_2,
  input  logic       btn_3,
  output logic       vote_candidate_1,
  output logic       vote_candidate_2,
  output logic       vote_candidate_3,
  output logic       ballot_ready,
  output logic       vote_rejected,
  output logic       ballot_timeout,
  output logic [7:0] ballots_cast
);

  typedef enum logic [2:0] {
    S_LOCKED   = 3'd0,
    S_ARMED    = 3'd1,
    S_DEBOUNCE = 3'd2,
    S_CAST     = 3'd3,
    S_RELEASE  = 3'd4
  } state_t;

  // Timers are down-counters: the load value is the number of further samples
  // needed after the current one before the terminal count is reached.
  localparam logic [7:0]  DEB_LOAD = 8'(DEBOUNCE_CYCLES - 2);
  localparam logic [7:0]  REL_LOAD = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [2:0]  sync_q, btn_s;
  logic [2:0]  pat_q, pat_d;
  logic        used_q, used_d;
  logic [15:0] tmo_q, tmo_d;
  logic [7:0]  deb_q, deb_d;
  logic [7:0]  rel_q, rel_d;
  logic [7:0]  count_q, count_d;
  logic [2:0]  vote_q, vote_d;
  logic        rej_q, rej_d;
  logic        tout_q, tout_d;
  logic        ready_q, ready_d;
  logic        pat_onehot;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      btn_s  <= '0;
    end else begin
      sync_q <= {btn_3, btn_2, btn_1};
      btn_s  <= sync_q;
    end
  end

  assign pat_onehot = (pat_q == 3'b001) || (pat_q == 3'b010) || (pat_q == 3'b100);

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    used_d  = used_q;
    tmo_d   = tmo_q;
    deb_d   = deb_q;
    rel_d   = rel_q;
    count_d = count_q;
    vote_d  = '0;
    rej_d   = 1'b0;
    tout_d  = 1'b0;
    unique case (state_q)
      S_LOCKED: begin
        if (arm) begin
          state_d = S_ARMED;
          tmo_d   = TMO_LOAD;
          used_d  = 1'b0;
        end
      end
      S_ARMED: begin
        // a press seen on the terminal-count edge wins over the timeout
        if (btn_s != 3'b000) begin
          pat_d   = btn_s;
          deb_d   = DEB_LOAD;
          state_d = S_DEBOUNCE;
        end else if (tmo_q == 16'd0) begin
          state_d = S_LOCKED;
          tout_d  = 1'b1;
        end else begin
          tmo_d = tmo_q - 16'd1;
        end
      end
      S_DEBOUNCE: begin
        if (btn_s != pat_q) begin
          state_d = S_ARMED;
          deb_d   = '0;
        end else if (deb_q == 8'd0) begin
          if (pat_onehot) begin
            state_d = S_CAST;
            vote_d  = pat_q;
          end else begin
            state_d = S_RELEASE;
            rel_d   = REL_LOAD;
            rej_d   = 1'b1;
          end
        end else begin
          deb_d = deb_q - 8'd1;
        end
      end
      S_CAST: begin
        count_d = count_q + 8'd1;
        used_d  = 1'b1;
        rel_d   = REL_LOAD;
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        // an unused ballot re-opens with the timeout window still running
        if (btn_s != 3'b000) begin
          rel_d = REL_LOAD;
        end else if (rel_q == 8'd0) begin
          state_d = used_q ? S_LOCKED : S_ARMED;
        end else begin
          rel_d = rel_q - 8'd1;
        end
      end
      default: state_d = S_LOCKED;
    endcase
    ready_d = (state_d == S_ARMED) || (state_d == S_DEBOUNCE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_LOCKED;
      pat_q   <= '0;
      used_q  <= 1'b0;
      tmo_q   <= '0;
      deb_q   <= '0;
      rel_q   <= '0;
      count_q <= '0;
      vote_q  <= '0;
      rej_q   <= 1'b0;
      tout_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      used_q  <= used_d;
      tmo_q   <= tmo_d;
      deb_q   <= deb_d;
      rel_q   <= rel_d;
      count_q <= count_d;
      vote_q  <= vote_d;
      rej_q   <= rej_d;
      tout_q  <= tout_d;
      ready_q <= ready_d;
    end
  end

  assign vote_candidate_1 = vote_q[0];
  assign vote_candidate_2 = vote_q[1];
  assign vote_candidate_3 = vote_q[2];
  assign vote_rejected    = rej_q;
  assign ballot_timeout   = tout_q;
  assign ballot_ready     = ready_q;
  assign ballots_cast     = count_q;

endmodule

// File: tb/tb_ballot_input_controller.sv
// Bench for ballot_input_controller: directed scenarios plus random button/arm
// traffic, every cycle compared against a ballot-level reference model.
module tb_ballot_input_controller;

  localparam int D = 4;
  localparam int T = 10;

  localparam int M_LOCKED  = 0;
  localparam int M_OPEN    = 1;
  localparam int M_SETTLE  = 2;
  localparam int M_VOTE    = 3;
  localparam int M_RELEASE = 4;

  logic       clk = 1'b0;
  logic       reset_n, arm, btn_1, btn_2, btn_3;
  logic       vote_candidate_1, vote_candidate_2, vote_candidate_3;
  logic       ballot_ready, vote_rejected, ballot_timeout;
  logic [7:0] ballots_cast;

  int n_checks = 0;
  int n_fail   = 0;

  ballot_input_controller #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .arm              (arm),
    .btn_1            (btn_1),
    .btn_2            (btn_2),
    .btn_3            (btn_3),
    .vote_candidate_1 (vote_candidate_1),
    .vote_candidate_2 (vote_candidate_2),
    .vote_candidate_3 (vote_candidate_3),
    .ballot_ready     (ballot_ready),
    .vote_rejected    (vote_rejected),
    .ballot_timeout   (ballot_timeout),
    .ballots_cast     (ballots_cast)
  );

  always #5 clk = ~clk;

  // reference model: phase of the ballot, samples seen through the 2-deep sync
  int         m_ph, idle, stable, zeros, votes_total;
  logic [2:0] pat, s1, s2, e_vote;
  bit         used, e_rej, e_tout, e_ready;
  int         obs_v1, obs_v2, obs_v3, obs_rej, obs_tout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = M_LOCKED; idle = 0; stable = 0; zeros = 0;
    pat = '0; s1 = '0; s2 = '0; used = 0; votes_total = 0;
    e_vote = '0; e_rej = 0; e_tout = 0; e_ready = 0;
  endtask

  task automatic model_step();
    logic [2:0] seen;
    if (!reset_n) begin
      model_reset();
      return;
    end
    seen = s2;
    e_vote = '0; e_rej = 0; e_tout = 0;
    case (m_ph)
      M_LOCKED: if (arm) begin m_ph = M_OPEN; idle = 0; used = 0; end
      M_OPEN: begin
        if (seen != 0) begin
          pat = seen; stable = 1; m_ph = M_SETTLE;
        end else begin
          idle++;
          if (idle == T) begin m_ph = M_LOCKED; e_tout = 1; end
        end
      end
      M_SETTLE: begin
        if (seen != pat) m_ph = M_OPEN;
        else if (stable == D - 1) begin
          if ($countones(pat) == 1) begin m_ph = M_VOTE; e_vote = pat; end
          else begin m_ph = M_RELEASE; zeros = 0; e_rej = 1; end
        end else stable++;
      end
      M_VOTE: begin
        votes_total = (votes_total + 1) % 256;
        used = 1; zeros = 0; m_ph = M_RELEASE;
      end
      M_RELEASE: begin
        zeros = (seen == 0) ? zeros + 1 : 0;
        if (zeros == D) m_ph = used ? M_LOCKED : M_OPEN;
      end
      default: m_ph = M_LOCKED;
    endcase
    e_ready = (m_ph == M_OPEN) || (m_ph == M_SETTLE);
    s2 = s1;
    s1 = {btn_3, btn_2, btn_1};
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("vote", {vote_candidate_3, vote_candidate_2, vote_candidate_1}, e_vote);
    check("rejected", vote_rejected, e_rej);
    check("timeout", ballot_timeout, e_tout);
    check("ready", ballot_ready, e_ready);
    check("ballots_cast", ballots_cast, votes_total);
    obs_v1   += vote_candidate_1;
    obs_v2   += vote_candidate_2;
    obs_v3   += vote_candidate_3;
    obs_rej  += vote_rejected;
    obs_tout += ballot_timeout;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_obs();
    obs_v1 = 0; obs_v2 = 0; obs_v3 = 0; obs_rej = 0; obs_tout = 0;
  endtask

  task automatic set_btn(input logic [2:0] b);
    {btn_3, btn_2, btn_1} = b;
  endtask

  task automatic arm_once();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  initial begin
    int lat, at, c0, segs;
    logic [2:0] b;
    reset_n = 1'b0; arm = 1'b0; set_btn(3'b000);
    model_reset();
    clear_obs();
    ticks(3);
    reset_n = 1'b1;
    check("rst_ready", ballot_ready, 0);
    check("rst_count", ballots_cast, 0);
    check("rst_pulses", {vote_candidate_3, vote_candidate_2, vote_candidate_1,
                         vote_rejected, ballot_timeout}, 0);
    ticks(2);

    // single press on candidate 2, latency measured from the first edge after press
    arm_once();
    clear_obs();
    set_btn(3'b010);
    lat = -1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (vote_candidate_2 && lat < 0) lat = i;
      if (i == 19) set_btn(3'b000);
    end
    check("t1_latency", lat, D + 1);
    check("t1_pulses", obs_v2, 1);
    check("t1_count", ballots_cast, 1);
    check("t1_ready", ballot_ready, 0);

    // bouncing contact, then stable
    arm_once();
    clear_obs();
    set_btn(3'b001); tick();
    set_btn(3'b000); tick();
    set_btn(3'b001); tick();
    set_btn(3'b000); tick();
    check("t2_bounce_quiet", obs_v1, 0);
    set_btn(3'b001); ticks(12);
    set_btn(3'b000); ticks(8);
    check("t2_pulses", obs_v1, 1);
    check("t2_count", ballots_cast, 2);

    // two buttons together are refused, then a retry on the same ballot
    arm_once();
    clear_obs();
    set_btn(3'b101); ticks(8);
    set_btn(3'b000); ticks(6);
    check("t3_ready_again", ballot_ready, 1);
    check("t3_rejects", obs_rej, 1);
    check("t3_no_vote", obs_v1 + obs_v3, 0);
    set_btn(3'b100); ticks(10);
    set_btn(3'b000); ticks(8);
    check("t3_retry_vote", obs_v3, 1);
    check("t3_count", ballots_cast, 3);

    // abandoned ballot times out; a later press is ignored
    arm_once();
    clear_obs();
    at = -1;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (ballot_timeout && at < 0) at = i + 1;
    end
    check("t4_timeout_at", at, T);
    check("t4_timeouts", obs_tout, 1);
    check("t4_ready", ballot_ready, 0);
    set_btn(3'b001); ticks(10);
    set_btn(3'b000); ticks(6);
    check("t4_no_vote", obs_v1, 0);

    // second press without re-arm
    arm_once();
    set_btn(3'b001); ticks(10);
    set_btn(3'b000); ticks(8);
    c0 = ballots_cast;
    clear_obs();
    set_btn(3'b001); ticks(10);
    set_btn(3'b000); ticks(8);
    check("t5_no_second", obs_v1, 0);
    check("t5_count_held", ballots_cast, c0);

    // reset while debouncing a press
    arm_once();
    set_btn(3'b001); ticks(3);
    reset_n = 1'b0;
    #1;
    model_reset();
    check("t6_rst_ready", ballot_ready, 0);
    check("t6_rst_count", ballots_cast, 0);
    check("t6_rst_pulses", {vote_candidate_3, vote_candidate_2, vote_candidate_1,
                            vote_rejected, ballot_timeout}, 0);
    ticks(2);
    set_btn(3'b000);
    reset_n = 1'b1;
    clear_obs();
    ticks(10);
    check("t6_lost_vote", obs_v1 + obs_v2 + obs_v3, 0);

    // 256 ballots wrap the counter
    clear_obs();
    for (int n = 0; n < 256; n++) begin
      arm_once();
      b = 3'b001 << $urandom_range(0, 2);
      set_btn(b); ticks(8);
      set_btn(3'b000); ticks(7);
    end
    check("t7_votes", obs_v1 + obs_v2 + obs_v3, 256);
    check("t7_wrap", ballots_cast, 0);

    // random traffic
    segs = 0;
    while (segs < 400) begin
      if ($urandom_range(0, 99) == 0) begin
        reset_n = 1'b0;
        #1;
        model_reset();
        tick();
        reset_n = 1'b1;
      end
      arm = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 19))
        0, 1, 2, 3, 4, 5, 6, 7, 8, 9: b = 3'b000;
        10, 11, 12, 13, 14, 15, 16:   b = 3'b001 << $urandom_range(0, 2);
        default:                      b = 3'($urandom_range(0, 7));
      endcase
      set_btn(b);
      ticks($urandom_range(1, 12));
      segs++;
    end
    arm = 1'b0;
    set_btn(3'b000);
    ticks(20);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
